regfile_shift_unit: RTL and testbench
=====================================

# regfile_shift_unit

Integer register file and immediate-shift datapath for the multicycle RV64 processor. Holds the 32 × 64-bit architectural registers x0..x31 with two combinational read ports and one synchronous write port. Also extracts the 6-bit shift amount from the instruction word and shifts the port-1 read value, producing the result the MemToReg write-back mux selects for `slli`, `srli` and `srai`.

## Interface
Parameters: none. Widths are fixed: 64-bit data, 32 registers, 5-bit register index, 6-bit shift amount.

- `Clk` input 1: the single clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-low; sampled on the `Clk` rising edge.
- `RegWrite` input 1: write enable for the register file.
- `ReadReg1` input 5: read port 1 index (instr[19:15]).
- `ReadReg2` input 5: read port 2 index (instr[24:20]).
- `WriteReg` input 5: write index (instr[11:7]).
- `WriteData` input 64: write data.
- `ReadData1` output 64: combinational contents of x[`ReadReg1`].
- `ReadData2` output 64: combinational contents of x[`ReadReg2`].
- `Inst` input 32: current instruction word from the IR.
- `Shift` input 2: shift operation select.
- `ShiftN` output 6: extracted shift amount, `Inst[25:20]`.
- `ShiftOut` output 64: `ReadData1` shifted by `ShiftN`.

## Operation
- **Storage:** 32 × 64-bit registers.
- **Register x0:**
  - Reads of x0 always return 0.
  - Writes to x0 are discarded.
- **Read ports:**
  - Purely combinational from the register array.
  - No write-to-read bypass: a read of the register being written returns the old value until after the edge.
- **Write:** on a rising edge of `Clk`, when `Reset`=1, `RegWrite`=1 and `WriteReg`≠0, x[`WriteReg`] ← `WriteData`.
- **Reset:** on a rising edge with `Reset`=0, all registers clear to 0. Reset has priority over a simultaneous write.
- **Shift amount:** `ShiftN` = `Inst[25:20]`, a full 6-bit RV64 shamt in the range 0..63. Combinational.
- **Shift operation** (combinational on `ReadData1`, `ShiftN`, `Shift`):
  - `Shift` = 00: SLL, logical left; zeros fill from the right.
  - `Shift` = 01: SRL, logical right; zeros fill from the left.
  - `Shift` = 10: SRA, arithmetic right; bit 63 replicated.
  - `Shift` = 11: pass-through, `ShiftOut` = `ReadData1`.
- **Shift by 0** returns the operand unchanged for every op.
- **Shift by 63:**
  - SLL leaves only bit 0, moved to bit 63.
  - SRL yields 0 or 1.
  - SRA yields all-ones or zero, depending on bit 63.

## Timing
- Read ports, `ShiftN` and `ShiftOut` have zero-cycle latency; they are combinational from their inputs and the register array.
- Write latency: one edge. Data is visible on the read ports immediately after the capturing edge.
- **Reset values:**
  - Every register is 0 after the first rising edge with `Reset`=0.
  - `ReadData1`, `ReadData2` and `ShiftOut` are therefore 0 from that point until the next write.
  - `ShiftN` depends only on `Inst`.
- Before the first reset edge, register contents are undefined. x0 still reads 0.
- **Reset asserted mid-sequence:** the pending write in that cycle is lost and all registers clear.
- Reading and writing the same index in the same cycle is legal; the read returns the pre-edge value.
- No handshakes. The control unit guarantees `RegWrite` is asserted only in write-back states.

## Structure
- **Shared package** `regfile_pkg`:
  - `XLEN`=64, `NREGS`=32, `REG_IDX_W`=5, `SHAMT_W`=6.
  - Enum `shift_op_e` {SLL=2'b00, SRL=2'b01, SRA=2'b10, PASS=2'b11}. The control unit imports this enum to drive `ShiftControl`.
- **Sub-module** `barrel_shifter64`: combinational, 6-stage log shifter handling the three shift ops plus pass-through.
- The top level holds the register array, the write/reset logic, the read muxes and the shamt extraction.

## Test plan
- **Reset clear:** write x5=0xDEAD_BEEF_0000_0001, then hold `Reset`=0 for one edge → `ReadData1` at `ReadReg1`=5 reads 0; all 32 indices read 0.
- **Write/read and x0:**
  - Write x7=0x0123_4567_89AB_CDEF and x0=0xFFFF_FFFF_FFFF_FFFF.
  - Required: `ReadReg1`=7 → 0x0123_4567_89AB_CDEF; `ReadReg2`=0 → 0.
  - Same-cycle read of x7 while writing 0x1 returns the old value before the edge and 0x1 after it.
- **Reset vs write priority:** `Reset`=0 and `RegWrite`=1 on the same edge with `WriteReg`=3, `WriteData`=0x55 → x3 reads 0.
- **Shamt extraction:** `Inst`=0x03F0_9093 (slli x1,x1,63) → `ShiftN`=63; `Inst`=0x0040_D093 (srli shamt 4) → `ShiftN`=4.
- **Shifts** with x1=0x8000_0000_0000_00F0 on `ReadData1`:
  - SLL 4 → 0x0000_0000_0000_0F00.
  - SRL 4 → 0x0800_0000_0000_000F.
  - SRA 4 → 0xF800_0000_0000_000F.
  - SRA 63 → 0xFFFF_FFFF_FFFF_FFFF.
  - Shift 0 → unchanged.
  - `Shift`=11 → unchanged.
- **Write-back loop:** x2=0x10; drive `WriteData`=`ShiftOut` with SLL 2 and `WriteReg`=4 for one edge → x4 reads 0x40.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and shift-op encoding for the RV64 integer register file and shift datapath.
package regfile_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned SHAMT_W   = 6;

    typedef enum logic [1:0] {
        SLL  = 2'b00,
        SRL  = 2'b01,
        SRA  = 2'b10,
        PASS = 2'b11
    } shift_op_e;

endpackage : regfile_pkg

// File: rtl/regfile_shift_unit_if.sv
// Register-file / shift-unit signal bundle between the control datapath and regfile_shift_unit.
interface regfile_shift_unit_if;
    import regfile_pkg::*;

    logic                 RegWrite;
    logic [REG_IDX_W-1:0] ReadReg1;
    logic [REG_IDX_W-1:0] ReadReg2;
    logic [REG_IDX_W-1:0] WriteReg;
    logic [XLEN-1:0]      WriteData;
    logic [XLEN-1:0]      ReadData1;
    logic [XLEN-1:0]      ReadData2;
    logic [31:0]          Inst;
    logic [1:0]           Shift;
    logic [SHAMT_W-1:0]   ShiftN;
    logic [XLEN-1:0]      ShiftOut;

    modport master (
        output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Inst, Shift,
        input  ReadData1, ReadData2, ShiftN, ShiftOut
    );

    modport slave (
        input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Inst, Shift,
        output ReadData1, ReadData2, ShiftN, ShiftOut
    );

endinterface : regfile_shift_unit_if

// File: rtl/barrel_shifter64.sv
// Combinational 6-stage logarithmic shifter: SLL / SRL / SRA, or pass-through.
module barrel_shifter64
    import regfile_pkg::*;
(
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_e          op_i,
    output logic [XLEN-1:0]    result_c
);

    logic [XLEN-1:0] stage;

    // Each stage conditionally shifts by 2**k; SRA replicates bit 63 at every stage.
    always_comb begin
        stage = data_i;
        for (int k = 0; k < int'(SHAMT_W); k++) begin
            if (shamt_i[k]) begin
                case (op_i)
                    SLL:     stage = stage << (1 << k);
                    SRL:     stage = stage >> (1 << k);
                    SRA:     stage = $signed(stage) >>> (1 << k);
                    default: stage = stage;
                endcase
            end
        end
        result_c = stage;
    end

endmodule : barrel_shifter64

// File: rtl/regfile_shift_unit.sv
// 32 x 64-bit RV64 integer register file with two combinational read ports,
// one synchronous write port, and the immediate-shift datapath on read port 1.
module regfile_shift_unit
    import regfile_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_shift_unit_if.slave  bus
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;
    logic [XLEN-1:0] shift_res_c;
    logic            unused_inst_bits;

    // Next-state of the array: only a qualified write to a non-zero index changes it.
    always_comb begin
        regs_d = regs_q;
        if (bus.RegWrite && (bus.WriteReg != '0)) begin
            regs_d[bus.WriteReg] = bus.WriteData;
        end
    end

    // Synchronous active-low reset wins over a simultaneous write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 is forced to zero on read, so it reads 0 even before the first reset.
    assign rd1_c = (bus.ReadReg1 == '0) ? '0 : regs_q[bus.ReadReg1];
    assign rd2_c = (bus.ReadReg2 == '0) ? '0 : regs_q[bus.ReadReg2];

    assign bus.ReadData1 = rd1_c;
    assign bus.ReadData2 = rd2_c;
    assign bus.ShiftN    = bus.Inst[25:20];

    assign unused_inst_bits = ^{bus.Inst[31:26], bus.Inst[19:0]};

    barrel_shifter64 u_shifter (
        .data_i   (rd1_c),
        .shamt_i  (bus.Inst[25:20]),
        .op_i     (shift_op_e'(bus.Shift)),
        .result_c (shift_res_c)
    );

    assign bus.ShiftOut = shift_res_c;

endmodule : regfile_shift_unit

// File: tb/tb_regfile_shift_unit.sv
// Directed self-checking bench for regfile_shift_unit.
module tb_regfile_shift_unit;
    import regfile_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    regfile_shift_unit_if bus ();

    regfile_shift_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle just past it so sampling is away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = idx;
        bus.WriteData = val;
        tick();
        bus.RegWrite  = 1'b0;
        #1;
    endtask

    initial begin
        bus.RegWrite  = 1'b0;
        bus.ReadReg1  = 5'd0;
        bus.ReadReg2  = 5'd0;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 64'd0;
        bus.Inst      = 32'd0;
        bus.Shift     = 2'b11;
        #2;
        check("x0_before_reset", bus.ReadData1, 64'd0);

        // Initial reset
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        bus.ReadReg1 = 5'd9;
        #1;
        check("post_reset_x9", bus.ReadData1, 64'd0);
        check("post_reset_shiftout", bus.ShiftOut, 64'd0);

        // Reset clear after a write
        write_reg(5'd5, 64'hDEAD_BEEF_0000_0001);
        bus.ReadReg1 = 5'd5;
        #1;
        check("x5_written", bus.ReadData1, 64'hDEAD_BEEF_0000_0001);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("x5_after_reset", bus.ReadData1, 64'd0);
        for (int i = 0; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), bus.ReadData1, 64'd0);
            check($sformatf("reset_rd2_x%0d", 31 - i), bus.ReadData2, 64'd0);
        end

        // Write/read and x0 discard
        write_reg(5'd7, 64'h0123_4567_89AB_CDEF);
        write_reg(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.ReadReg1 = 5'd7;
        bus.ReadReg2 = 5'd0;
        #1;
        check("x7_read", bus.ReadData1, 64'h0123_4567_89AB_CDEF);
        check("x0_write_discarded", bus.ReadData2, 64'd0);

        // Same-cycle read of the register being written: no bypass
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd7;
        bus.WriteData = 64'h1;
        #1;
        check("x7_pre_edge_old", bus.ReadData1, 64'h0123_4567_89AB_CDEF);
        tick();
        bus.RegWrite = 1'b0;
        #1;
        check("x7_post_edge_new", bus.ReadData1, 64'h1);

        // Reset has priority over a simultaneous write
        bus.ReadReg2  = 5'd3;
        Reset         = 1'b0;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd3;
        bus.WriteData = 64'h55;
        tick();
        Reset        = 1'b1;
        bus.RegWrite = 1'b0;
        #1;
        check("reset_beats_write_x3", bus.ReadData2, 64'd0);
        check("reset_clears_x7", bus.ReadData1, 64'd0);

        // Shamt extraction
        bus.Inst = 32'h03F0_9093;
        #1;
        check("shamt_63", 64'(bus.ShiftN), 64'd63);
        bus.Inst = 32'h0040_D093;
        #1;
        check("shamt_4", 64'(bus.ShiftN), 64'd4);

        // Shifts on x1
        write_reg(5'd1, 64'h8000_0000_0000_00F0);
        bus.ReadReg1 = 5'd1;
        bus.Inst = 32'h0040_D093;
        bus.Shift = 2'b00; #1; check("sll_4", bus.ShiftOut, 64'h0000_0000_0000_0F00);
        bus.Shift = 2'b01; #1; check("srl_4", bus.ShiftOut, 64'h0800_0000_0000_000F);
        bus.Shift = 2'b10; #1; check("sra_4", bus.ShiftOut, 64'hF800_0000_0000_000F);
        bus.Shift = 2'b11; #1; check("pass_4", bus.ShiftOut, 64'h8000_0000_0000_00F0);
        bus.Inst = 32'h03F0_9093;
        bus.Shift = 2'b10; #1; check("sra_63", bus.ShiftOut, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.Shift = 2'b01; #1; check("srl_63", bus.ShiftOut, 64'h1);
        bus.Shift = 2'b00; #1; check("sll_63_bit0_clear", bus.ShiftOut, 64'h0);
        bus.Inst = 32'h0000_9093;
        bus.Shift = 2'b00; #1; check("sll_0", bus.ShiftOut, 64'h8000_0000_0000_00F0);
        bus.Shift = 2'b01; #1; check("srl_0", bus.ShiftOut, 64'h8000_0000_0000_00F0);
        bus.Shift = 2'b10; #1; check("sra_0", bus.ShiftOut, 64'h8000_0000_0000_00F0);

        // Edge cases with other operands
        write_reg(5'd6, 64'h7000_0000_0000_0001);
        bus.ReadReg1 = 5'd6;
        bus.Inst = 32'h03F0_9093;
        bus.Shift = 2'b00; #1; check("sll_63_bit0_set", bus.ShiftOut, 64'h8000_0000_0000_0000);
        bus.Shift = 2'b10; #1; check("sra_63_positive", bus.ShiftOut, 64'h0);
        bus.Inst = 32'h0210_9093;
        bus.Shift = 2'b10; #1; check("sra_33_positive", bus.ShiftOut, 64'h0000_0000_3800_0000);

        // Write-back loop: x4 <= x2 << 2
        write_reg(5'd2, 64'h10);
        bus.ReadReg1 = 5'd2;
        bus.Inst     = 32'h0020_9093;
        bus.Shift    = 2'b00;
        #1;
        bus.WriteData = bus.ShiftOut;
        bus.WriteReg  = 5'd4;
        bus.RegWrite  = 1'b1;
        tick();
        bus.RegWrite = 1'b0;
        bus.ReadReg2 = 5'd4;
        #1;
        check("writeback_x4", bus.ReadData2, 64'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_shift_unit
